// File: rtl/literal_bank_writer_pkg.sv
`default_nettype none
// snappy_pkg: history-RAM geometry, literal-writer error codes, beat record and beat checker.
package snappy_pkg;

  localparam int NUM_BANKS = 16;
  localparam int BANK_AW   = 9;
  localparam int LINE_W    = 64;
  localparam int BE_W      = LINE_W / 8;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_BANK_SEL   = 2'd1;
  localparam logic [1:0] ERR_EMPTY_MASK = 2'd2;
  localparam logic [1:0] ERR_MASK_SHAPE = 2'd3;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_ERROR = 1'b1
  } writer_state_t;

  typedef struct packed {
    logic [NUM_BANKS-1:0] bank;
    logic [BANK_AW-1:0]   addr;
    logic [LINE_W-1:0]    data;
    logic [BE_W-1:0]      be;
  } lit_beat_t;

  // A legal mask is a run of ones starting at bit 7, so its complement is a run of ones from bit 0.
  function automatic logic [1:0] beat_check(input logic [NUM_BANKS-1:0] sel,
                                            input logic [BE_W-1:0]      be);
    logic [BE_W-1:0] inv;
    logic [1:0]      code;
    inv = ~be;
    if (sel == '0 || (sel & (sel - NUM_BANKS'(1))) != '0)
      code = ERR_BANK_SEL;
    else if (be == '0)
      code = ERR_EMPTY_MASK;
    else if ((inv & (inv + BE_W'(1))) != '0)
      code = ERR_MASK_SHAPE;
    else
      code = ERR_NONE;
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/literal_bank_writer_if.sv
`default_nettype none
// literal_bank_writer_if: parser literal-beat input and history-RAM bank write port.
interface literal_bank_writer_if;
  import snappy_pkg::*;

  logic [NUM_BANKS-1:0] in_valid;
  logic [LINE_W-1:0]    in_data;
  logic [BE_W-1:0]      in_byte_valid;
  logic [BANK_AW-1:0]   in_address;
  logic                 in_ready;
  logic [NUM_BANKS-1:0] bank_busy;
  logic [NUM_BANKS-1:0] wr_en;
  logic [BANK_AW-1:0]   wr_addr;
  logic [LINE_W-1:0]    wr_data;
  logic [BE_W-1:0]      wr_be;

  modport master (
    output in_valid, in_data, in_byte_valid, in_address, bank_busy,
    input  in_ready, wr_en, wr_addr, wr_data, wr_be
  );

  modport slave (
    input  in_valid, in_data, in_byte_valid, in_address, bank_busy,
    output in_ready, wr_en, wr_addr, wr_data, wr_be
  );
endinterface
`default_nettype wire

// File: rtl/literal_bank_writer_fifo.sv
`default_nettype none
// lit_fifo2: two-entry literal-beat FIFO; head is always the oldest entry (or stale/zero when empty).
module lit_fifo2
  import snappy_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  lit_beat_t  push_beat,
  input  logic       pop,
  output lit_beat_t  head,
  output logic [1:0] count
);

  lit_beat_t mem [2];
  logic      wr_ptr;
  logic      rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_beat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/literal_bank_writer.sv
`default_nettype none
// literal_bank_writer: checks parser literal beats, queues up to two, writes them to history-RAM banks.
// Optional write statistics counters are built when LITERAL_WRITER_STATS_EN is defined.
module literal_bank_writer
  import snappy_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  literal_bank_writer_if.slave bus,
  output logic                 idle,
  output logic                 err,
  output logic [1:0]           err_code
`ifdef LITERAL_WRITER_STATS_EN
  ,
  output logic [31:0]          byte_count,
  output logic [31:0]          beat_count
`endif
);

  writer_state_t state;
  lit_beat_t     head;
  lit_beat_t     in_beat;
  logic [1:0]    count;
  logic [1:0]    beat_code;
  logic          accept;
  logic          push;
  logic          pop;
  logic          head_blocked;

  // Ready is decoded from registered state only, so it never depends on bank_busy or in_valid.
  assign bus.in_ready = (state == ST_ERROR) || (count != 2'd2);
  assign accept       = (bus.in_valid != '0) && bus.in_ready;
  assign beat_code    = beat_check(bus.in_valid, bus.in_byte_valid);
  assign push         = accept && (state == ST_RUN) && (beat_code == ERR_NONE);

  assign in_beat.bank = bus.in_valid;
  assign in_beat.addr = bus.in_address;
  assign in_beat.data = bus.in_data;
  assign in_beat.be   = bus.in_byte_valid;

  lit_fifo2 u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_beat (in_beat),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // A busy head bank stalls the whole queue to keep writes in acceptance order.
  assign head_blocked = |(head.bank & bus.bank_busy);
  assign pop          = (count != 2'd0) && !head_blocked;

  assign bus.wr_en   = pop ? head.bank : '0;
  assign bus.wr_addr = head.addr;
  assign bus.wr_data = head.data;
  assign bus.wr_be   = head.be;
  assign idle        = (count == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      case (state)
        ST_RUN: begin
          if (accept && beat_code != ERR_NONE) begin
            state    <= ST_ERROR;
            err      <= 1'b1;
            err_code <= beat_code;
          end
        end
        ST_ERROR: begin
          state <= ST_ERROR;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

`ifdef LITERAL_WRITER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_count <= 32'd0;
      beat_count <= 32'd0;
    end else if (pop) begin
      byte_count <= byte_count + 32'($countones(head.be));
      beat_count <= beat_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_literal_bank_writer.sv
`default_nettype none
// tb_literal_bank_writer: scoreboard bench; expected writes are queued at accept and popped on wr_en.
module tb_literal_bank_writer;
  import snappy_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        idle;
  logic        err;
  logic [1:0]  err_code;
`ifdef LITERAL_WRITER_STATS_EN
  logic [31:0] byte_count;
  logic [31:0] beat_count;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  int          wr_count = 0;
  lit_beat_t   sb[$];
  logic        m_err = 1'b0;

  literal_bank_writer_if bus_if ();

  literal_bank_writer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_if.slave),
    .idle     (idle),
    .err      (err),
    .err_code (err_code)
`ifdef LITERAL_WRITER_STATS_EN
    ,
    .byte_count (byte_count),
    .beat_count (beat_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_code(input logic [15:0] v, input logic [7:0] be);
    if ($countones(v) != 1) return 2'd1;
    if (be == 8'h00) return 2'd2;
    if (!(be inside {8'hff, 8'hfe, 8'hfc, 8'hf8, 8'hf0, 8'he0, 8'hc0, 8'h80})) return 2'd3;
    return 2'd0;
  endfunction

  // Scoreboard consumer
  always @(negedge clk) begin
    lit_beat_t e;
    if (!rst_n) begin
      check("wr_in_reset", bus_if.wr_en, 0);
    end else if (bus_if.wr_en != '0) begin
      if (sb.size() == 0) begin
        check("unexp_wr", bus_if.wr_en, 0);
      end else begin
        e = sb.pop_front();
        check("wr_en", bus_if.wr_en, e.bank);
        check("wr_addr", bus_if.wr_addr, e.addr);
        check("wr_data", bus_if.wr_data, e.data);
        check("wr_be", bus_if.wr_be, e.be);
        wr_count++;
      end
    end
  end

  task automatic do_reset();
    rst_n                = 1'b0;
    bus_if.in_valid      = '0;
    bus_if.in_data       = '0;
    bus_if.in_byte_valid = '0;
    bus_if.in_address    = '0;
    bus_if.bank_busy     = '0;
    sb.delete();
    m_err = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [15:0] v, input logic [8:0] a, input logic [7:0] be,
                      input logic [63:0] d);
    int        waits;
    lit_beat_t b;
    logic [1:0] c;
    @(negedge clk);
    bus_if.in_valid      = v;
    bus_if.in_address    = a;
    bus_if.in_byte_valid = be;
    bus_if.in_data       = d;
    waits = 0;
    while (!bus_if.in_ready && waits < 64) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 64) begin
      check("ready_timeout", bus_if.in_ready, 1);
    end else if (!m_err) begin
      c = exp_code(v, be);
      if (c == 2'd0) begin
        b.bank = v; b.addr = a; b.data = d; b.be = be;
        sb.push_back(b);
      end else begin
        m_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    bus_if.in_valid = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, bus_if.in_ready, 1);
    check({tag, "_wr_en"}, bus_if.wr_en, 0);
    check({tag, "_wr_addr"}, bus_if.wr_addr, 0);
    check({tag, "_wr_data"}, bus_if.wr_data, 0);
    check({tag, "_wr_be"}, bus_if.wr_be, 0);
    check({tag, "_idle"}, idle, 1);
    check({tag, "_err"}, err, 0);
    check({tag, "_err_code"}, err_code, 0);
`ifdef LITERAL_WRITER_STATS_EN
    check({tag, "_byte_count"}, byte_count, 0);
    check({tag, "_beat_count"}, beat_count, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // 1: reset values and single-beat latency
    do_reset();
    #1;
    check_reset_values("rst");
    send(16'h0001, 9'h005, 8'hc0, {16'h0d0a, 48'h1234_5678_9abc});
    check("t1_latency_wr_en", bus_if.wr_en, 16'h0001);
    check("t1_wr_data_top", bus_if.wr_data[63:48], 16'h0d0a);
    @(posedge clk);
    #1;
    check("t1_idle_after", idle, 1);
`ifdef LITERAL_WRITER_STATS_EN
    check("t1_byte_count", byte_count, 2);
    check("t1_beat_count", beat_count, 1);
`endif

    // 2: busy head bank blocks queue; order 3, 3, 7 after release
    do_reset();
    bus_if.bank_busy = 16'h0008;
    send(16'h0008, 9'h010, 8'hff, 64'h1111_1111_1111_1111);
    send(16'h0008, 9'h011, 8'hf0, 64'h2222_2222_2222_2222);
    fork
      send(16'h0080, 9'h012, 8'h80, 64'h3333_3333_3333_3333);
      begin
        repeat (3) begin
          @(negedge clk);
          check("t2_ready_low", bus_if.in_ready, 0);
          check("t2_no_wr_busy", bus_if.wr_en, 0);
        end
        @(posedge clk);
        #1;
        bus_if.bank_busy = '0;
        @(negedge clk);
        check("t2_order0", bus_if.wr_en, 16'h0008);
        @(negedge clk);
        check("t2_order1", bus_if.wr_en, 16'h0008);
        @(negedge clk);
        check("t2_order2", bus_if.wr_en, 16'h0080);
      end
    join
    repeat (2) @(negedge clk);
    check("t2_idle", idle, 1);

    // 3: non-one-hot bank select
    do_reset();
    send(16'h0003, 9'h001, 8'hff, 64'hdead_beef_0000_0001);
    check("t3_err", err, 1);
    check("t3_err_code", err_code, 1);
    check("t3_ready", bus_if.in_ready, 1);
    send(16'h0004, 9'h002, 8'hff, 64'hdead_beef_0000_0002);
    repeat (2) begin
      @(negedge clk);
      check("t3_no_wr", bus_if.wr_en, 0);
    end

    // 4: first error cause is kept
    do_reset();
    send(16'h0004, 9'h003, 8'h3c, 64'h0);
    check("t4_err_code_first", err_code, 3);
    send(16'h0004, 9'h004, 8'h00, 64'h0);
    check("t4_err_code_kept", err_code, 3);
    check("t4_err", err, 1);

    // 5: steady one-beat-per-cycle stream
    do_reset();
    base = wr_count;
    for (int i = 0; i < 100; i++) begin
      send((i % 2 == 0) ? 16'h0001 : 16'h0002, 9'(i), 8'hff, {$urandom, $urandom});
      check("t5_wr_each_cycle", |bus_if.wr_en, 1);
      check("t5_not_idle", idle, 0);
    end
    repeat (2) @(negedge clk);
    check("t5_writes", wr_count - base, 100);
    check("t5_idle_end", idle, 1);
`ifdef LITERAL_WRITER_STATS_EN
    check("t5_beat_count", beat_count, 100);
    check("t5_byte_count", byte_count, 800);
`endif

    // 6: short reset pulse with two queued beats
    do_reset();
    bus_if.bank_busy = 16'h0010;
    send(16'h0010, 9'h020, 8'hff, 64'haaaa_aaaa_aaaa_aaaa);
    send(16'h0010, 9'h021, 8'hff, 64'hbbbb_bbbb_bbbb_bbbb);
    check("t6_full", bus_if.in_ready, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_reset_values("t6_rst");
    #1;
    rst_n = 1'b1;
    bus_if.bank_busy = '0;
    repeat (4) begin
      @(negedge clk);
      check("t6_no_wr", bus_if.wr_en, 0);
    end
    check("t6_idle", idle, 1);

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/literal_bank_writer.md
# literal_bank_writer

Consumes literal beats from the Snappy token parser and writes them into the 16 banks of the history RAM. Buffers up to two beats so that a bank-busy stall does not immediately back-pressure the parser. Checks each beat for a well-formed bank select and byte mask, and latches the first protocol error.

## Interface
- No parameters. Widths are fixed by the history RAM: 16 banks, 512 lines per bank, 64-bit lines.
- `clk`  in  1  — single clock.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `in_valid`  in  16  — one-hot bank select for the beat; 0 means no beat.
- `in_data`  in  64  — literal bytes, MSB-first (byte 7 = `[63:56]`).
- `in_byte_valid`  in  8  — byte mask; bit 7 corresponds to `in_data[63:56]`.
- `in_address`  in  9  — line address inside the selected bank.
- `in_ready`  out  1  — block can take a beat this cycle.
- `bank_busy`  in  16  — bank n cannot accept a write this cycle.
- `wr_en`  out  16  — one-hot write strobe to bank n.
- `wr_addr`  out  9  — write line address, shared by all banks.
- `wr_data`  out  64  — write data, shared by all banks.
- `wr_be`  out  8  — byte enables, same bit order as `in_byte_valid`.
- `idle`  out  1  — FIFO empty.
- `err`  out  1  — sticky protocol error.
- `err_code`  out  2  — cause of the first error.
- `byte_count`  out  32  — only with `LITERAL_WRITER_STATS_EN`.
- `beat_count`  out  32  — only with `LITERAL_WRITER_STATS_EN`.

## Operation
- **Accept rule.** A beat is accepted in a cycle where `in_valid != 0` and `in_ready == 1`.
  - When `in_ready == 0`, upstream holds the beat; the block ignores it.
- **Beat check at accept:**
  - `in_valid` not one-hot → `err_code = 1`.
  - else `in_byte_valid == 0` → `err_code = 2`.
  - else mask not MSB-contiguous → `err_code = 3`. Legal masks are ff, fe, fc, f8, f0, e0, c0, 80.
  - A failing beat is dropped, `err` goes to 1, and the FSM moves RUN→ERROR.
  - `err_code` holds the first cause only.
- **FIFO.** Good beats are pushed into a 2-entry FIFO that stores {bank, addr, data, be}.
- **Write issue.**
  - When the FIFO is non-empty and `bank_busy[head.bank] == 0`: `wr_en = head.bank`, the other write outputs take the head fields, and the head is popped.
  - Otherwise `wr_en = 0`. `wr_addr`, `wr_data` and `wr_be` hold the head fields regardless.
- **FSM states:**
  - RUN: normal accept, check and push.
  - ERROR: `in_ready` is forced to 1. Every beat is accepted and discarded. The FIFO drains normally. The FSM leaves ERROR only on reset.
- **Stats.** Each issued write adds popcount(`wr_be`) to `byte_count` and 1 to `beat_count`. Both counters wrap modulo 2^32.

## Timing
- **Reset values (asynchronous):**
  - FIFO empty, FSM in RUN.
  - `in_ready = 1`, `wr_en = 0`, `wr_addr`, `wr_data` and `wr_be` = 0.
  - `idle = 1`, `err = 0`, `err_code = 0`, counters = 0.
- **Latency.** A beat accepted in cycle N is at the FIFO head in cycle N+1. If its bank is free, `wr_en` is asserted in N+1.
- **`in_ready`.** In RUN it is `count < 2`, decoded from the registered count. It has no combinational path from `bank_busy` or `in_valid`.
- **Simultaneous push and pop.**
  - Allowed at count 1: count stays 1.
  - At count 2 only a pop is possible, so count goes to 1 and `in_ready` rises in the next cycle.
- **Write-port paths.** `wr_en` depends combinationally on `bank_busy` and on registered head state only.
- **Ordering.** Writes leave in acceptance order. A busy head bank blocks the second entry, even if that entry targets a free bank.
- **Error beat.** It is consumed in its accept cycle and never reaches `wr_en`. Beats already queued are still written.
- **Mid-operation reset.** Queued beats are lost. No `wr_en` pulse may occur while `rst_n` is low.

## Configuration
- `LITERAL_WRITER_STATS_EN`:
  - Defined: `byte_count` and `beat_count` ports and their counter logic exist.
  - Undefined: the ports are absent and no counter flops exist. All other behaviour is identical.

## Structure
- **Shared package `snappy_pkg`:**
  - `NUM_BANKS = 16`, `BANK_AW = 9`, `LINE_W = 64`.
  - Error-code constants `ERR_NONE = 0`, `ERR_BANK_SEL = 1`, `ERR_EMPTY_MASK = 2`, `ERR_MASK_SHAPE = 3`.
  - Typedef `lit_beat_t` = {bank, addr, data, be}.
- **Sub-module `lit_fifo2`:** the 2-entry FIFO with push/pop/count.
- The checker, the FSM and the stats logic stay in the top level.

## Test plan
1. Reset, then beat `in_valid = 16'h0001`, `in_address = 9'h005`, `in_byte_valid = 8'hc0`, `in_data[63:48] = 16'h0d0a`, bank free.
   - Required: in the next cycle `wr_en = 16'h0001`, `wr_addr = 5`, `wr_be = c0`, `wr_data[63:48] = 0d0a`.
   - With STATS: `byte_count = 2`.
2. `bank_busy[3]` held high while beats go to banks 3, 3 and 7.
   - Required: `in_ready` falls after the second accept, nothing is written while busy, and the 7-beat waits behind the two 3-beats.
   - After release: writes occur in order 3, 3, 7 on consecutive cycles.
3. Beat with `in_valid = 16'h0003`.
   - Required: dropped, `err = 1`, `err_code = 1`, `in_ready` stays 1.
   - A later good beat produces no `wr_en`.
4. Beat with mask 8'h3c, then a beat with mask 8'h00.
   - Required: `err_code = 3`, which is kept after the second error.
5. Steady push/pop with one beat per cycle to alternating banks 0 and 1, all banks free.
   - Required: one `wr_en` per cycle, `idle` never high during the burst.
   - With STATS after 100 `ff` beats: `beat_count = 100`, `byte_count = 800`.
6. Assert `rst_n` low for part of a cycle while the FIFO holds 2 beats.
   - Required: outputs return to their reset values immediately, and no write appears after release.
